// File: rtl/digital_theremin_freq_counter.sv
// rtl/digital_theremin_freq_counter.sv - gated edge counter for a theremin oscillator, Avalon-MM register access
// Define FREQ_COUNTER_AVG4_EN to report the average of the last four gate windows instead of the raw count.
module digital_theremin_freq_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        gate_tick,
  input  logic        osc_in,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COUNTING = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        osc_meta, osc_sync, osc_prev;
  logic        gate_prev, tick;
  logic        count_edge;
  logic        wr, rd, status_wr, ctrl_wr, en_wr, dis_wr;
  logic        window_end, produce;
  logic        enable, irq_en;
  logic        valid, overrun;
  logic [31:0] cnt, result, new_result;
  logic [15:0] hold;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[15:2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      osc_meta  <= 1'b0;
      osc_sync  <= 1'b0;
      osc_prev  <= 1'b0;
      gate_prev <= 1'b0;
      tick      <= 1'b0;
    end else begin
      osc_meta  <= osc_in;
      osc_sync  <= osc_meta;
      osc_prev  <= osc_sync;
      gate_prev <= gate_tick;
      tick      <= gate_tick & ~gate_prev;
    end
  end

  assign count_edge = osc_sync & ~osc_prev;

  assign wr        = chipselect & ~write_n;
  assign rd        = chipselect & write_n;
  assign status_wr = wr && (address == 3'd0);
  assign ctrl_wr   = wr && (address == 3'd1);
  assign en_wr     = ctrl_wr && writedata[0];
  assign dis_wr    = ctrl_wr && !writedata[0];

  // A disable in the same cycle as the tick wins, so that window is dropped.
  assign window_end = (state == COUNTING) && tick && !dis_wr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (en_wr) state_nxt = ARMED;
      ARMED:    if (tick)  state_nxt = COUNTING;
      COUNTING: state_nxt = COUNTING;
      default:  state_nxt = IDLE;
    endcase
    if (dis_wr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An edge coinciding with the closing tick belongs to the next window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 32'd0;
    end else if (dis_wr || (state != COUNTING)) begin
      cnt <= 32'd0;
    end else if (tick) begin
      cnt <= {31'd0, count_edge};
    end else if (count_edge && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

`ifdef FREQ_COUNTER_AVG4_EN
  logic [31:0] hist [0:2];
  logic [1:0]  win_cnt;
  logic [33:0] sum4;
  logic        arm;
  logic        unused_sum;

  assign arm        = (state == IDLE) && en_wr;
  assign sum4       = {2'b00, cnt} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
  assign new_result = sum4[33:2];
  assign unused_sum = ^sum4[1:0];
  assign produce    = window_end && (win_cnt == 2'd3);

  // Three previous windows plus the one closing now form the four-window average.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist[0] <= 32'd0;
      hist[1] <= 32'd0;
      hist[2] <= 32'd0;
      win_cnt <= 2'd0;
    end else if (arm) begin
      hist[0] <= 32'd0;
      hist[1] <= 32'd0;
      hist[2] <= 32'd0;
      win_cnt <= 2'd0;
    end else if (window_end) begin
      hist[0] <= cnt;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      if (win_cnt != 2'd3) win_cnt <= win_cnt + 2'd1;
    end
  end
`else
  assign new_result = cnt;
  assign produce    = window_end;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result  <= 32'd0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      enable  <= 1'b0;
      irq_en  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        enable <= writedata[0];
        irq_en <= writedata[1];
      end
      if (produce) begin
        result  <= new_result;
        valid   <= 1'b1;
        overrun <= valid | (overrun & ~status_wr);
      end else if (status_wr) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  // Reading the low half freezes the high half so a 2-then-3 read pair is coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold     <= 16'd0;
      readdata <= 16'd0;
    end else if (rd) begin
      if (address == 3'd2) hold <= result[31:16];
      case (address)
        3'd0:    readdata <= {14'd0, overrun, valid};
        3'd1:    readdata <= {14'd0, irq_en, enable};
        3'd2:    readdata <= result[15:0];
        3'd3:    readdata <= hold;
        default: readdata <= 16'd0;
      endcase
    end
  end

  assign irq = valid & irq_en;

endmodule

// File: tb/tb_digital_theremin_freq_counter.sv
// tb/tb_digital_theremin_freq_counter.sv - directed scoreboard bench for digital_theremin_freq_counter
module tb_digital_theremin_freq_counter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'd0;
  logic [15:0] readdata;
  logic        gate_tick = 1'b0;
  logic        osc_in = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  digital_theremin_freq_counter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .gate_tick  (gate_tick),
    .osc_in     (osc_in),
    .irq        (irq)
  );

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   osc_per = 0;
  int   t;
  logic rd_seen = 1'b0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, act, exp);
    end
  endtask

  always @(posedge clk) rd_seen <= chipselect & write_n & reset_n;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: readdata 0x%04h with no expected entry", readdata);
      end else begin
        mon_e = sb_q.pop_front();
        check(mon_e.name, readdata, mon_e.exp);
      end
    end
  end

  // Oscillator rises on every cycle index that is a multiple of osc_per.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (osc_per != 0) osc_in = ((cyc % osc_per) < (osc_per / 2));
  endtask

  task automatic wait_to(input int c);
    if (cyc > c) begin
      n_checks++;
      n_errors++;
      $display("FAIL schedule: cycle %0d already past %0d", cyc, c);
    end
    while (cyc < c) step();
  endtask

  task automatic tick_at(input int c);
    wait_to(c);
    gate_tick = 1'b1;
    step();
    step();
    gate_tick = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    step();
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [15:0] e, input string nm);
    sb_t item;
    step();
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    item.name  = nm;
    item.exp   = e;
    sb_q.push_back(item);
    step();
    chipselect = 1'b0;
  endtask

  function automatic int next5();
    return ((cyc / 10) + 3) * 10 + 5;
  endfunction

  initial begin
    repeat (3) step();
    check("reset_readdata", readdata, 16'h0000);
    check("reset_irq", {15'd0, irq}, 16'h0000);
    reset_n = 1'b1;
    bus_read(0, 16'h0000, "reset_status");
    bus_read(1, 16'h0000, "reset_control");
    bus_read(2, 16'h0000, "reset_result_lo");
    bus_read(3, 16'h0000, "reset_result_hi");
    bus_read(5, 16'h0000, "unmapped5");

`ifdef FREQ_COUNTER_AVG4_EN
    osc_per = 10;
    bus_write(1, 16'h0003);
    t = next5();
    tick_at(t);
    tick_at(t + 1000);
    tick_at(t + 3000);
    tick_at(t + 6000);
    bus_read(0, 16'h0000, "avg4_not_valid_after_3");
    tick_at(t + 10000);
    bus_read(0, 16'h0001, "avg4_valid_at_4");
    bus_read(2, 16'd250, "avg4_result_lo");
    bus_read(3, 16'h0000, "avg4_result_hi");
`else
    // Basic count: 5000-cycle windows, osc period 10 -> 500 edges.
    osc_per = 10;
    bus_write(1, 16'h0003);
    bus_read(1, 16'h0003, "control_rb");
    tick_at(1005);
    bus_read(0, 16'h0000, "no_result_on_arm_tick");
    tick_at(6005);
    bus_read(2, 16'h01F4, "basic_lo");
    bus_read(3, 16'h0000, "basic_hi");
    bus_read(0, 16'h0001, "basic_status");
    check("basic_irq", {15'd0, irq}, 16'h0001);
    bus_write(2, 16'h1234);
    bus_read(2, 16'h01F4, "result_write_ignored");
    bus_read(6, 16'h0000, "unmapped6");

    tick_at(11005);
    bus_read(0, 16'h0003, "overrun_status");
    bus_write(0, 16'h0000);
    bus_read(0, 16'h0000, "status_cleared");
    check("irq_after_clear", {15'd0, irq}, 16'h0000);

    // Atomic read: 262142-cycle window at one edge per 2 cycles -> 0x1FFFF.
    bus_write(1, 16'h0000);
    bus_write(0, 16'h0000);
    osc_per = 2;
    bus_write(1, 16'h0003);
    tick_at(12000);
    tick_at(12000 + 262142);
    bus_read(2, 16'hFFFF, "atomic_lo");
    tick_at(12000 + 262142 + 40);
    bus_read(3, 16'h0001, "atomic_hi_held");
    bus_read(2, 16'h0014, "after_atomic_lo");
    bus_read(3, 16'h0000, "after_atomic_hi");

    // Collision: an edge lands on the tick that closes the first window.
    bus_write(1, 16'h0000);
    bus_write(0, 16'h0000);
    osc_per = 10;
    bus_write(1, 16'h0003);
    t = next5();
    tick_at(t);
    tick_at(t + 996);
    bus_read(2, 16'd99, "collision_prev_window");
    tick_at(t + 2000);
    bus_read(2, 16'd101, "collision_restart_at_1");

    bus_write(0, 16'h0000);
    wait_to(t + 3005);
    gate_tick  = 1'b1;
    step();
    address    = 3'd0;
    writedata  = 16'h0000;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    gate_tick  = 1'b0;
    bus_read(0, 16'h0001, "status_write_vs_tick");
    bus_read(2, 16'd100, "status_write_vs_tick_result");

    // Disable on the same cycle as a tick: no result.
    bus_write(0, 16'h0000);
    wait_to(t + 4005);
    gate_tick  = 1'b1;
    step();
    address    = 3'd1;
    writedata  = 16'h0000;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    gate_tick  = 1'b0;
    bus_read(0, 16'h0000, "disable_vs_tick_status");
    bus_read(2, 16'd100, "disable_vs_tick_result");

    // Reset mid-window discards the partial count.
    bus_write(1, 16'h0003);
    t = next5();
    tick_at(t);
    tick_at(t + 1000);
    check("pre_reset_irq", {15'd0, irq}, 16'h0001);
    wait_to(t + 1500);
    reset_n = 1'b0;
    #1;
    check("reset_async_irq", {15'd0, irq}, 16'h0000);
    check("reset_async_readdata", readdata, 16'h0000);
    step();
    step();
    reset_n = 1'b1;
    bus_read(0, 16'h0000, "post_reset_status");
    bus_read(1, 16'h0000, "post_reset_control");
    bus_read(2, 16'h0000, "post_reset_result_lo");
    bus_read(3, 16'h0000, "post_reset_result_hi");
    tick_at(t + 2000);
    bus_read(0, 16'h0000, "post_reset_tick_while_idle");
    bus_write(1, 16'h0003);
    t = next5();
    tick_at(t);
    bus_read(0, 16'h0000, "post_reset_after_arm_tick");
    tick_at(t + 1000);
    bus_read(0, 16'h0001, "post_reset_result_status");
    bus_read(2, 16'd100, "post_reset_result");
`endif

    repeat (3) step();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d reads never answered, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
